// File: rtl/gru_fx_pkg.sv
// Shared fixed-point constants, FSM state type and clamp helper for the GRU
// gradient-accumulation datapath (signed Q2.14 data, Q10.14 accumulator).
package gru_fx_pkg;
    localparam int DATABIT = 16;
    localparam int FRAC    = 14;
    localparam int ACCW    = 24;
    localparam int CNTW    = 8;

    localparam logic [DATABIT-1:0] Q_ONE = 16'h4000;
    localparam logic [DATABIT-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DATABIT-1:0] Q_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        SCALE = 2'd3
    } gru_state_e;

    // Clamp a Q10.14 accumulator value into Q2.14; returns {clip, value}.
    function automatic logic [DATABIT:0] sat16_acc(input logic [ACCW-1:0] v);
        logic [DATABIT:0] r;
        if ((&v[ACCW-1:DATABIT-1]) || !(|v[ACCW-1:DATABIT-1])) begin
            r = {1'b0, v[DATABIT-1:0]};
        end else if (v[ACCW-1]) begin
            r = {1'b1, Q_MIN};
        end else begin
            r = {1'b1, Q_MAX};
        end
        return r;
    endfunction
endpackage

// File: rtl/fx_sat16.sv
// Round-half-up and shift a 32-bit Q4.28 product back to Q2.14; provides the
// unclamped 18-bit result plus a 16-bit clamped copy with a clip flag.
module fx_sat16
    import gru_fx_pkg::*;
(
    input  logic [2*DATABIT-1:0] i_prod,
    output logic [DATABIT+1:0]   o_round,
    output logic [DATABIT-1:0]   o_sat,
    output logic                 o_clip
);
    localparam logic [2*DATABIT:0] RND = 33'h0_0000_2000;

    logic [2*DATABIT:0] w_biased;
    logic               w_round_unused;

    // Sign-extend by one bit so adding the rounding constant can never wrap.
    assign w_biased       = {i_prod[2*DATABIT-1], i_prod} + RND;
    assign o_round        = w_biased[FRAC+DATABIT+1:FRAC];
    assign w_round_unused = ^{w_biased[2*DATABIT], w_biased[FRAC-1:0]};

    // Clip when the bits above Q2.14 are not a pure sign extension.
    always_comb begin
        o_clip = 1'b0;
        o_sat  = o_round[DATABIT-1:0];
        if ((&o_round[DATABIT+1:DATABIT-1]) || !(|o_round[DATABIT+1:DATABIT-1])) begin
            o_clip = 1'b0;
            o_sat  = o_round[DATABIT-1:0];
        end else begin
            o_clip = 1'b1;
            o_sat  = o_round[DATABIT+1] ? Q_MIN : Q_MAX;
        end
    end
endmodule

// File: rtl/gru_grad_accum.sv
// Per-weight GRU gradient accumulator: sums rounded delta*operand products over
// one sequence, then scales the clamped sum by the learning rate to emit dw.
module gru_grad_accum
    import gru_fx_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNTW-1:0]    seq_len,
    input  logic [DATABIT-1:0] lr,
    input  logic               delta_valid,
    output logic               in_ready,
    input  logic [DATABIT-1:0] delta,
    input  logic [DATABIT-1:0] operand,
    output logic               busy,
    output logic               dw_valid,
    output logic [DATABIT-1:0] dw,
    output logic               sat
);
    gru_state_e r_state;
    gru_state_e w_state_nx;

    logic [CNTW-1:0]      r_len;
    logic [CNTW-1:0]      r_cnt;
    logic [DATABIT-1:0]   r_lr;
    logic                 r_in_vld;
    logic [DATABIT-1:0]   r_delta;
    logic [DATABIT-1:0]   r_op;
    logic                 r_prod_vld;
    logic [ACCW-1:0]      r_prod;
    logic [ACCW-1:0]      r_acc;
    logic [DATABIT-1:0]   r_dw;
    logic                 r_dw_valid;
    logic                 r_sat;

    logic                 w_start;
    logic                 w_accept;
    logic [2*DATABIT-1:0] w_mul_prod;
    logic [DATABIT+1:0]   w_prod_round;
    logic [DATABIT-1:0]   w_prod_unused_sat;
    logic                 w_prod_unused_clip;
    logic [ACCW:0]        w_acc_sum;
    logic [ACCW-1:0]      w_acc_nx;
    logic                 w_acc_ovf;
    logic                 w_acc_clip;
    logic [DATABIT-1:0]   w_acc16;
    logic [2*DATABIT-1:0] w_scale_mul;
    logic [DATABIT+1:0]   w_scale_unused_round;
    logic [DATABIT-1:0]   w_dw;
    logic                 w_dw_clip;

    assign in_ready = (r_state == ACCUM) && (r_cnt < r_len);
    assign busy     = (r_state != IDLE);
    assign dw_valid = r_dw_valid;
    assign dw       = r_dw;
    assign sat      = r_sat;

    assign w_start  = start && (r_state == IDLE);
    assign w_accept = delta_valid && in_ready;

    assign w_mul_prod = $signed({{DATABIT{r_delta[DATABIT-1]}}, r_delta})
                      * $signed({{DATABIT{r_op[DATABIT-1]}}, r_op});

    fx_sat16 u_prod (
        .i_prod  (w_mul_prod),
        .o_round (w_prod_round),
        .o_sat   (w_prod_unused_sat),
        .o_clip  (w_prod_unused_clip)
    );

    assign {w_acc_clip, w_acc16} = sat16_acc(r_acc);
    assign w_scale_mul = $signed({{DATABIT{w_acc16[DATABIT-1]}}, w_acc16})
                       * $signed({{DATABIT{r_lr[DATABIT-1]}}, r_lr});

    fx_sat16 u_scale (
        .i_prod  (w_scale_mul),
        .o_round (w_scale_unused_round),
        .o_sat   (w_dw),
        .o_clip  (w_dw_clip)
    );

    assign w_acc_sum = {r_acc[ACCW-1], r_acc} + {r_prod[ACCW-1], r_prod};

    // Saturating accumulate: overflow when the extra sign bit disagrees.
    always_comb begin
        w_acc_ovf = 1'b0;
        w_acc_nx  = w_acc_sum[ACCW-1:0];
        if (w_acc_sum[ACCW] != w_acc_sum[ACCW-1]) begin
            w_acc_ovf = 1'b1;
            w_acc_nx  = w_acc_sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
        end else begin
            w_acc_ovf = 1'b0;
            w_acc_nx  = w_acc_sum[ACCW-1:0];
        end
    end

    // DRAIN ends once the input stage is empty: the last product lands in acc on that edge.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nx = (seq_len == 8'd0) ? SCALE : ACCUM;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            ACCUM: begin
                if (w_accept && ((r_cnt + 8'd1) == r_len)) begin
                    w_state_nx = DRAIN;
                end else begin
                    w_state_nx = ACCUM;
                end
            end
            DRAIN: begin
                if (!r_in_vld) begin
                    w_state_nx = SCALE;
                end else begin
                    w_state_nx = DRAIN;
                end
            end
            SCALE:   w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // State, pipeline, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_len      <= {CNTW{1'b0}};
            r_cnt      <= {CNTW{1'b0}};
            r_lr       <= {DATABIT{1'b0}};
            r_in_vld   <= 1'b0;
            r_delta    <= {DATABIT{1'b0}};
            r_op       <= {DATABIT{1'b0}};
            r_prod_vld <= 1'b0;
            r_prod     <= {ACCW{1'b0}};
            r_acc      <= {ACCW{1'b0}};
            r_dw       <= {DATABIT{1'b0}};
            r_dw_valid <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_in_vld   <= w_accept;
            r_prod_vld <= r_in_vld;
            r_dw_valid <= (r_state == SCALE);
            if (w_accept) begin
                r_delta <= delta;
                r_op    <= operand;
                r_cnt   <= r_cnt + 8'd1;
            end
            if (r_in_vld) begin
                r_prod <= {{(ACCW-DATABIT-2){w_prod_round[DATABIT+1]}}, w_prod_round};
            end
            if (r_state == SCALE) begin
                r_dw <= w_dw;
            end
            if (w_start) begin
                r_len <= seq_len;
                r_lr  <= lr;
                r_cnt <= {CNTW{1'b0}};
                r_acc <= {ACCW{1'b0}};
                r_sat <= 1'b0;
            end else begin
                if (r_prod_vld) begin
                    r_acc <= w_acc_nx;
                end
                if ((r_prod_vld && w_acc_ovf) || ((r_state == SCALE) && (w_acc_clip || w_dw_clip))) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_gru_grad_accum.sv
// Self-checking bench for gru_grad_accum: directed sequences plus random ones,
// compared against an integer reference model of the gradient/update rules.
module tb_gru_grad_accum;
    import gru_fx_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  seq_len;
    logic [15:0] lr;
    logic        delta_valid;
    logic        in_ready;
    logic [15:0] delta;
    logic [15:0] operand;
    logic        busy;
    logic        dw_valid;
    logic [15:0] dw;
    logic        sat;

    always #5 clk = ~clk;

    gru_grad_accum dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .seq_len     (seq_len),
        .lr          (lr),
        .delta_valid (delta_valid),
        .in_ready    (in_ready),
        .delta       (delta),
        .operand     (operand),
        .busy        (busy),
        .dw_valid    (dw_valid),
        .dw          (dw),
        .sat         (sat)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] d_arr [256];
    logic [15:0] o_arr [256];
    logic [15:0] exp_dw;
    logic        exp_sat;
    logic [15:0] last_dw;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: integer sum of rounded products with clamping, then scaled by lr.
    task automatic model(input int len, input logic [15:0] lr_v);
        longint acc = 64'sd0;
        longint p;
        longint r;
        bit     s = 1'b0;
        for (int i = 0; i < len; i++) begin
            p = (longint'($signed(d_arr[i])) * longint'($signed(o_arr[i])) + 64'sd8192) >>> 14;
            acc = acc + p;
            if (acc > 64'sd8388607) begin
                acc = 64'sd8388607;
                s = 1'b1;
            end else if (acc < -64'sd8388608) begin
                acc = -64'sd8388608;
                s = 1'b1;
            end
        end
        if (acc > 64'sd32767) begin
            acc = 64'sd32767;
            s = 1'b1;
        end else if (acc < -64'sd32768) begin
            acc = -64'sd32768;
            s = 1'b1;
        end
        r = (acc * longint'($signed(lr_v)) + 64'sd8192) >>> 14;
        if (r > 64'sd32767) begin
            r = 64'sd32767;
            s = 1'b1;
        end else if (r < -64'sd32768) begin
            r = -64'sd32768;
            s = 1'b1;
        end
        exp_dw  = r[15:0];
        exp_sat = s;
    endtask

    function automatic logic [15:0] rnd_q();
        logic [31:0] u;
        u = $urandom();
        case (u[2:0])
            3'd0:    return 16'h7FFF;
            3'd1:    return 16'h8000;
            default: return u[31:16];
        endcase
    endfunction

    // Runs one sequence starting at the current negedge; returns at the dw_valid cycle.
    task automatic run_seq(input int len, input logic [15:0] lr_v, input int gap_max,
                           input bit extra, input string tag);
        int k;
        int gap;
        model(len, lr_v);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        start   = 1'b1;
        seq_len = len[7:0];
        lr      = lr_v;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_vld0"}, 32'(dw_valid), 32'd0);
        check({tag, "_satclr"}, 32'(sat), 32'd0);
        check({tag, "_dwhold"}, 32'(dw), 32'(last_dw));
        check({tag, "_rdy0"}, 32'(in_ready), 32'(len != 0));
        for (int i = 0; i < len; i++) begin
            gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int g = 0; g < gap; g++) begin
                delta_valid = 1'b0;
                delta       = rnd_q();
                operand     = rnd_q();
                @(negedge clk);
            end
            delta_valid = 1'b1;
            delta       = d_arr[i];
            operand     = o_arr[i];
            if (extra && i == 0) begin
                start   = 1'b1;
                seq_len = 8'd3;
                lr      = 16'h1234;
            end
            check({tag, "_rdy"}, 32'(in_ready), 32'd1);
            @(negedge clk);
            start = 1'b0;
        end
        k = 1;
        if (len > 0) begin
            check({tag, "_rdy_done"}, 32'(in_ready), 32'd0);
        end
        delta_valid = extra;
        start       = extra;
        delta       = 16'h7FFF;
        operand     = 16'h7FFF;
        seq_len     = 8'd2;
        while (dw_valid !== 1'b1 && k < 12) begin
            @(negedge clk);
            k++;
            delta_valid = 1'b0;
            start       = 1'b0;
        end
        check({tag, "_lat"}, 32'(k), (len == 0) ? 32'd2 : 32'd4);
        check({tag, "_dw"}, 32'(dw), 32'(exp_dw));
        check({tag, "_sat"}, 32'(sat), 32'(exp_sat));
        check({tag, "_idle_end"}, 32'(busy), 32'd0);
        last_dw = exp_dw;
    endtask

    initial begin
        int len;
        rst = 1'b1; start = 1'b0; delta_valid = 1'b0;
        seq_len = 8'd0; lr = 16'h0000; delta = 16'h0000; operand = 16'h0000;
        last_dw = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_rdy", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_vld", 32'(dw_valid), 32'd0);
        check("rst_dw", 32'(dw), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        d_arr[0] = 16'h4000; o_arr[0] = 16'h2000;
        run_seq(1, Q_ONE, 0, 1'b0, "t1");
        check("t1_const", 32'(dw), 32'h2000);
        check("t1_sat_const", 32'(sat), 32'd0);

        for (int i = 0; i < 4; i++) begin d_arr[i] = 16'h2000; o_arr[i] = 16'h2000; end
        run_seq(4, 16'h0666, 0, 1'b0, "t2");
        check("t2_const", 32'(dw), 32'h0666);

        for (int i = 0; i < 8; i++) begin d_arr[i] = 16'h7FFF; o_arr[i] = 16'h7FFF; end
        run_seq(8, Q_ONE, 0, 1'b0, "t3");
        check("t3_const", 32'(dw), 32'h7FFF);
        check("t3_sat_const", 32'(sat), 32'd1);

        // Reset with two samples still in the pipeline.
        start = 1'b1; seq_len = 8'd4; lr = Q_ONE;
        @(negedge clk);
        start = 1'b0; delta_valid = 1'b1; delta = 16'h4000; operand = 16'h4000;
        @(negedge clk);
        @(negedge clk);
        delta_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("t5_rdy", 32'(in_ready), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_vld", 32'(dw_valid), 32'd0);
        check("t5_dw", 32'(dw), 32'd0);
        check("t5_sat", 32'(sat), 32'd0);
        rst = 1'b0;
        last_dw = 16'h0000;
        @(negedge clk);
        d_arr[0] = 16'h4000; o_arr[0] = 16'h2000;
        run_seq(1, Q_ONE, 0, 1'b0, "t5b");
        check("t5b_const", 32'(dw), 32'h2000);

        run_seq(0, Q_ONE, 0, 1'b0, "t4");
        check("t4_const", 32'(dw), 32'h0000);

        d_arr[0] = 16'hC000; o_arr[0] = 16'h4000;
        run_seq(1, Q_ONE, 0, 1'b1, "t6");
        check("t6_const", 32'(dw), 32'hC000);

        // Accumulator clamps rather than wraps.
        for (int i = 0; i < 128; i++) begin d_arr[i] = 16'h8000; o_arr[i] = 16'h8000; end
        run_seq(128, Q_ONE, 0, 1'b0, "t7p");
        check("t7p_const", 32'(dw), 32'h7FFF);
        for (int i = 0; i < 129; i++) begin d_arr[i] = 16'h8000; o_arr[i] = 16'h7FFF; end
        run_seq(129, Q_ONE, 0, 1'b0, "t7n");
        check("t7n_const", 32'(dw), 32'h8000);

        for (int n = 0; n < 30; n++) begin
            len = int'($urandom_range(0, 12));
            for (int i = 0; i < len; i++) begin
                d_arr[i] = rnd_q();
                o_arr[i] = rnd_q();
            end
            run_seq(len, rnd_q(), 2, 1'($urandom_range(0, 1)), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
